// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Control, datapath and program-memory signals around the fetch
//            sequencer; master = surrounding core, slave = sequencer.
// Revision : 1.0
// ============================================================================
interface fetch_sequencer_if;
  logic        halt;
  logic [7:0]  mem_rdata;
  logic        MC;
  logic        J;
  logic [15:0] jaddr;
  logic        WC;
  logic        carry_in;
  logic [15:0] pc;
  logic [7:0]  inst;
  logic        cycle;
  logic        carry;
  logic [15:0] instret;

  modport master (
    output halt, mem_rdata, MC, J, jaddr, WC, carry_in,
    input  pc, inst, cycle, carry, instret
  );

  modport slave (
    input  halt, mem_rdata, MC, J, jaddr, WC, carry_in,
    output pc, inst, cycle, carry, instret
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC / instruction register / phase / carry / retire counter for a
//            one- or two-cycle-per-instruction core.
// Revision : 1.0
// ============================================================================
module fetch_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  localparam logic [15:0] C_PC_RESET   = 16'h0000;
  localparam logic [7:0]  C_NOP        = 8'h00;

  phase_e      phase_q, phase_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  inst_q, inst_d;
  logic        carry_q, carry_d;
  logic [15:0] instret_q, instret_d;
  logic        adv;

  // adv is low only in the first phase of a two-cycle instruction
  always_comb begin
    adv       = ~((phase_q == PH_FIRST) & bus.MC);
    phase_d   = phase_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    carry_d   = carry_q;
    instret_d = instret_q;
    if (!bus.halt) begin
      if (!adv) begin
        phase_d = PH_SECOND;
      end else begin
        phase_d   = PH_FIRST;
        instret_d = instret_q + 16'd1;
        if (bus.J) begin
          // the byte already fetched behind the jump is squashed to a NOP
          pc_d   = bus.jaddr;
          inst_d = C_NOP;
        end else begin
          pc_d   = pc_q + 16'd1;
          inst_d = bus.mem_rdata;
        end
        if (bus.WC) begin
          carry_d = bus.carry_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= PH_FIRST;
      pc_q      <= C_PC_RESET;
      inst_q    <= C_NOP;
      carry_q   <= 1'b0;
      instret_q <= 16'h0000;
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      carry_q   <= carry_d;
      instret_q <= instret_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.inst    = inst_q;
  assign bus.cycle   = (phase_q == PH_SECOND);
  assign bus.carry   = carry_q;
  assign bus.instret = instret_q;

endmodule
`default_nettype wire
